ibutterfly2_pipe: RTL and testbench

- Pipelined radix-2 inverse butterfly for the IFFT16 path. It undoes the forward butterfly2 stage.
- Sum and difference are formed, then halved.
- The difference is multiplied by the conjugate Q1.7 twiddle conj(W16^k), and the product is rescaled by 2^-7.
- Three-stage valid/ready pipeline. Sits between the IFFT stage sequencer and the stage buffer.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/cmul_q7.sv | 76 +++++++
 rtl/ibutterfly2_pipe.sv | 102 ++++++++++
 tb/tb_ibutterfly2_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath widths, complex sample type and inverse twiddle constants.
package fft_pkg;

    localparam int DATA_W  = 64;
    localparam int TW_W    = 8;
    localparam int TW_FRAC = 7;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // One extra bit so that +1.0 (128) is representable next to -1.0.
    typedef logic signed [TW_W:0] tw_t;

    // conj(W16^k) = cos(2*pi*k/16) + j*sin(2*pi*k/16), scaled by 2^TW_FRAC
    localparam tw_t TW_INV_R [8] = '{
        9'sd128, 9'sd118, 9'sd91, 9'sd49, 9'sd0, -9'sd49, -9'sd91, -9'sd118
    };
    localparam tw_t TW_INV_I [8] = '{
        9'sd0, 9'sd49, 9'sd91, 9'sd118, 9'sd128, 9'sd118, 9'sd91, 9'sd49
    };

endpackage

// File: rtl/cmul_q7.sv
// Two-stage complex multiply by a Q1.7 twiddle with round-half-up rescale.
// Carries an opaque sideband word alongside the product; all registers hold while en is low.
module cmul_q7
    import fft_pkg::*;
#(
    parameter int SB_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            valid_in,
    input  cplx_t           d,
    input  tw_t             tw_re,
    input  tw_t             tw_im,
    input  logic [SB_W-1:0] side_in,
    output logic            valid_out,
    output cplx_t           prod,
    output logic [SB_W-1:0] side_out
);

    localparam int PW = DATA_W + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));

    logic signed [PW-1:0] d_re_x;
    logic signed [PW-1:0] d_im_x;
    logic signed [PW-1:0] tw_re_x;
    logic signed [PW-1:0] tw_im_x;
    logic signed [PW-1:0] p_re_c;
    logic signed [PW-1:0] p_im_c;
    logic signed [PW-1:0] p_re_q;
    logic signed [PW-1:0] p_im_q;
    logic signed [PW-1:0] r_re_c;
    logic signed [PW-1:0] r_im_c;
    logic                 v2_q;
    logic [SB_W-1:0]      side2_q;

    assign d_re_x  = PW'(d.re);
    assign d_im_x  = PW'(d.im);
    assign tw_re_x = PW'(tw_re);
    assign tw_im_x = PW'(tw_im);

    // The exact product fits in PW bits, so PW-wide modular arithmetic is exact.
    assign p_re_c = d_re_x * tw_re_x - d_im_x * tw_im_x;
    assign p_im_c = d_re_x * tw_im_x + d_im_x * tw_re_x;

    assign r_re_c = (p_re_q + RND) >>> TW_FRAC;
    assign r_im_c = (p_im_q + RND) >>> TW_FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            p_re_q  <= '0;
            p_im_q  <= '0;
            side2_q <= '0;
        end else if (en) begin
            v2_q    <= valid_in;
            p_re_q  <= p_re_c;
            p_im_q  <= p_im_c;
            side2_q <= side_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            prod      <= '0;
            side_out  <= '0;
        end else if (en) begin
            valid_out <= v2_q;
            prod.re   <= DATA_W'(r_re_c);
            prod.im   <= DATA_W'(r_im_c);
            side_out  <= side2_q;
        end
    end

endmodule

// File: rtl/ibutterfly2_pipe.sv
// Pipelined radix-2 inverse butterfly: halved sum/difference, then the difference
// is rotated by conj(W16^k). Three register stages under a single advance enable.
module ibutterfly2_pipe
    import fft_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_Real_in,
    input  logic signed [DATA_W-1:0] a_Im_in,
    input  logic signed [DATA_W-1:0] b_Real_in,
    input  logic signed [DATA_W-1:0] b_Im_in,
    input  logic [2:0]               tw_idx,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] a_Real_out,
    output logic signed [DATA_W-1:0] a_Im_out,
    output logic signed [DATA_W-1:0] b_Real_out,
    output logic signed [DATA_W-1:0] b_Im_out,
    output logic [TAG_W-1:0]         tag_out
);

    localparam int SB_W = 2 * DATA_W + TAG_W;

    logic                   adv;
    logic signed [DATA_W:0] sum_re_c;
    logic signed [DATA_W:0] sum_im_c;
    logic signed [DATA_W:0] dif_re_c;
    logic signed [DATA_W:0] dif_im_c;

    logic             s1_valid;
    cplx_t            s1_s;
    cplx_t            s1_d;
    tw_t              s1_tw_re;
    tw_t              s1_tw_im;
    logic [TAG_W-1:0] s1_tag;

    logic [SB_W-1:0]  side_in;
    logic [SB_W-1:0]  side_out;
    cplx_t            s3_s;
    cplx_t            s3_b;

    // The output register is the only place a stall can originate.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign sum_re_c = (DATA_W+1)'(a_Real_in) + (DATA_W+1)'(b_Real_in);
    assign sum_im_c = (DATA_W+1)'(a_Im_in)   + (DATA_W+1)'(b_Im_in);
    assign dif_re_c = (DATA_W+1)'(a_Real_in) - (DATA_W+1)'(b_Real_in);
    assign dif_im_c = (DATA_W+1)'(a_Im_in)   - (DATA_W+1)'(b_Im_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_d     <= '0;
            s1_tw_re <= '0;
            s1_tw_im <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_s.re  <= DATA_W'(sum_re_c >>> 1);
            s1_s.im  <= DATA_W'(sum_im_c >>> 1);
            s1_d.re  <= DATA_W'(dif_re_c >>> 1);
            s1_d.im  <= DATA_W'(dif_im_c >>> 1);
            s1_tw_re <= TW_INV_R[tw_idx];
            s1_tw_im <= TW_INV_I[tw_idx];
            s1_tag   <= tag_in;
        end
    end

    // The halved sum and the tag ride through the multiplier as sideband.
    assign side_in = {s1_s, s1_tag};

    cmul_q7 #(
        .SB_W (SB_W)
    ) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .valid_in  (s1_valid),
        .d         (s1_d),
        .tw_re     (s1_tw_re),
        .tw_im     (s1_tw_im),
        .side_in   (side_in),
        .valid_out (out_valid),
        .prod      (s3_b),
        .side_out  (side_out)
    );

    assign {s3_s, tag_out} = side_out;

    assign a_Real_out = s3_s.re;
    assign a_Im_out   = s3_s.im;
    assign b_Real_out = s3_b.re;
    assign b_Im_out   = s3_b.im;

endmodule

// File: tb/tb_ibutterfly2_pipe.sv
// Self-checking bench for ibutterfly2_pipe: directed cases, backpressure, reset
// mid-stream and randomized traffic against a wide-integer reference model.
module tb_ibutterfly2_pipe;
    import fft_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic signed [DATA_W-1:0] a_re_i, a_im_i, b_re_i, b_im_i;
    logic signed [DATA_W-1:0] a_re_o, a_im_o, b_re_o, b_im_o;
    logic [2:0]       tw_idx;
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;

    always #5 clk = ~clk;

    ibutterfly2_pipe #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_Real_in  (a_re_i),
        .a_Im_in    (a_im_i),
        .b_Real_in  (b_re_i),
        .b_Im_in    (b_im_i),
        .tw_idx     (tw_idx),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a_Real_out (a_re_o),
        .a_Im_out   (a_im_o),
        .b_Real_out (b_re_o),
        .b_Im_out   (b_im_o),
        .tag_out    (tag_out)
    );

    typedef struct packed {
        logic [63:0] ar;
        logic [63:0] ai;
        logic [63:0] br;
        logic [63:0] bi;
        logic [3:0]  tag;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur_exp;
    beat_t snap;
    bit    hold_prev = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    bit    rand_done;

    int tw_r[8] = '{128, 118, 91, 49, 0, -49, -91, -118};
    int tw_i[8] = '{0, 49, 91, 118, 128, 118, 91, 49};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input longint ar, ai, br, bi, input logic [3:0] tg);
        beat_t r;
        r.ar = ar; r.ai = ai; r.br = br; r.bi = bi; r.tag = tg;
        return r;
    endfunction

    // Reference: floor-halved sum/difference, exact complex product, round half up.
    function automatic beat_t model(input logic signed [63:0] ar, ai, br, bi,
                                    input int k, input logic [3:0] tg);
        logic signed [127:0] sr, si, dr, di, wr, wi, pr, pi, qr, qi;
        beat_t r;
        sr = (128'(ar) + 128'(br)) >>> 1;
        si = (128'(ai) + 128'(bi)) >>> 1;
        dr = (128'(ar) - 128'(br)) >>> 1;
        di = (128'(ai) - 128'(bi)) >>> 1;
        wr = 128'(tw_r[k]);
        wi = 128'(tw_i[k]);
        pr = dr * wr - di * wi;
        pi = dr * wi + di * wr;
        qr = (pr + 128'sd64) >>> 7;
        qi = (pi + 128'sd64) >>> 7;
        r.ar = sr[63:0]; r.ai = si[63:0];
        r.br = qr[63:0]; r.bi = qi[63:0];
        r.tag = tg;
        return r;
    endfunction

    // Scoreboard: handshakes are decided at the coming posedge, sampled here.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (hold_prev) begin
                check_val("stable_a_re", a_re_o, snap.ar);
                check_val("stable_a_im", a_im_o, snap.ai);
                check_val("stable_b_re", b_re_o, snap.br);
                check_val("stable_b_im", b_im_o, snap.bi);
                check_val("stable_tag", 64'(tag_out), 64'(snap.tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("a_re", a_re_o, e.ar);
                    check_val("a_im", a_im_o, e.ai);
                    check_val("b_re", b_re_o, e.br);
                    check_val("b_im", b_im_o, e.bi);
                    check_val("tag", 64'(tag_out), 64'(e.tag));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
        hold_prev <= out_valid && !out_ready && !rst;
        snap      <= mk(a_re_o, a_im_o, b_re_o, b_im_o, tag_out);
    end

    task automatic send_beat(input logic signed [63:0] ar, ai, br, bi,
                             input logic [2:0] k, input logic [3:0] tg, input beat_t e);
        bit acc = 1'b0;
        a_re_i = ar; a_im_i = ai; b_re_i = br; b_im_i = bi;
        tw_idx = k; tag_in = tg; cur_exp = e;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !acc; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready && !rst;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand(input logic [3:0] tg);
        logic signed [63:0] v[4];
        logic [2:0] k;
        for (int j = 0; j < 4; j++) begin
            case ($urandom_range(0, 2))
                0:       v[j] = {$urandom, $urandom};
                1:       v[j] = 64'($urandom_range(0, 2000)) - 64'd1000;
                default: v[j] = ($urandom_range(0, 1) != 0) ? 64'h7FFF_FFFF_FFFF_FFFF
                                                            : 64'h8000_0000_0000_0000;
            endcase
        end
        k = 3'($urandom_range(0, 7));
        send_beat(v[0], v[1], v[2], v[3], k, tg, model(v[0], v[1], v[2], v[3], int'(k), tg));
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string pfx);
        check_val({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check_val({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
        check_val({pfx, "_a_re"}, a_re_o, 64'd0);
        check_val({pfx, "_a_im"}, a_im_o, 64'd0);
        check_val({pfx, "_b_re"}, b_re_o, 64'd0);
        check_val({pfx, "_b_im"}, b_im_o, 64'd0);
        check_val({pfx, "_tag"}, 64'(tag_out), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_re_i = '0; a_im_i = '0; b_re_i = '0; b_im_i = '0;
        tw_idx = '0; tag_in = '0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;

        // Directed values with hand-computed results
        send_beat(256, 0, 128, 0, 3'd0, 4'd1, mk(192, 0, 64, 0, 4'd1));
        send_beat(0, 0, -256, 0, 3'd4, 4'd2, mk(-128, 0, 0, 128, 4'd2));
        send_beat(0, 0, -256, 0, 3'd2, 4'd3, mk(-128, 0, 91, 91, 4'd3));
        send_beat(2, 0, 0, 0, 3'd1, 4'd4, mk(1, 0, 1, 0, 4'd4));
        send_beat(-3, 0, 0, 0, 3'd0, 4'd5, mk(-2, 0, -2, 0, 4'd5));
        drain();

        // Backpressure: six beats, downstream stalls 5 cycles after first output
        out_ready = 1'b1;
        fork
            begin
                for (int t = 0; t < 6; t++) send_rand(4'(t));
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!out_valid && w < 30) begin
                    @(negedge clk);
                    w++;
                end
                check_val("bp_first_out", 64'(out_valid), 64'd1);
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("bp_in_ready", 64'(in_ready), 64'd0);
                    check_val("bp_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight; rst must also win over in_valid
        send_rand(4'd6);
        send_rand(4'd7);
        send_rand(4'd8);
        rst = 1'b1;
        in_valid = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (8) @(negedge clk);
        check_val("midrst_quiet", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic with random gaps and random downstream stalls
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 200; t++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk); #1;
                        end
                    send_rand(4'(t));
                end
                rand_done = 1'b1;
            end
            begin
                int n = 0;
                while (!rand_done && n < 5000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
